// File: rtl/dec_nx_bist.sv
// ---------------------------------------------------------------------------
// dec_nx_bist
//
// Registered N-to-2**N one-hot decoder with enable, runtime fault injection
// and a built-in self-test sequencer that sweeps every code and reports the
// number of failing codes and the lowest failing code.
//
// Parameters:
//   N           address width, 2..6; output width is 2**N
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   en          normal-mode decode enable
//   a           normal-mode address
//   fault_sel   bit0: upper half of the output stuck at 0
//               bit1: address LSB inverted
//   start       single-cycle pulse that launches a BIST sweep
//   d           registered decoder output
//   busy        high while the sweep or its final check is in progress
//   done        high once a sweep has finished; results are held
//   pass        valid with done, 1 when no code failed
//   err_cnt     number of failing codes in the last sweep
//   first_fail  lowest failing code in the last sweep
//   fail_vld    first_fail holds a valid code
// ---------------------------------------------------------------------------
module dec_nx_bist #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     a,
    input  logic [1:0]       fault_sel,
    input  logic             start,
    output logic [2**N-1:0]  d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N:0]       err_cnt,
    output logic [N-1:0]     first_fail,
    output logic             fail_vld
);

    localparam int W = 2**N;
    localparam int H = W / 2;

    localparam logic [W-1:0] ONE_HOT0 = {{(W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   ERR_ONE  = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]   ERR_MAX  = {1'b1, {N{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   cnt;
    logic [1:0]     fault_lat;

    logic           bist_mode;
    logic           start_acc;
    logic           last_code;

    logic           core_en;
    logic [N-1:0]   core_addr;
    logic [1:0]     core_fault;
    logic [N-1:0]   eff_addr;
    logic [W-1:0]   raw;

    logic           check_en;
    logic [N-1:0]   chk_code;
    logic [W-1:0]   ideal;
    logic           mismatch;

    logic [N:0]     err_nxt;
    logic [N-1:0]   ff_nxt;
    logic           fv_nxt;

    assign bist_mode = (state == RUN) || (state == DRAIN);
    assign busy      = bist_mode;
    // start is only honoured when no sweep is in progress
    assign start_acc = start && ((state == IDLE) || (state == DONE));
    assign last_code = (cnt == {N{1'b1}});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: RUN spends one cycle per code, DRAIN checks the
    // output produced by the last code, DONE holds until the next start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_code) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode core. During a sweep the counter drives the address with the
    // enable forced on, and the fault selection is the value captured at
    // start so that live changes cannot disturb the sweep.
    always_comb begin
        core_en    = bist_mode ? 1'b1 : en;
        core_addr  = bist_mode ? cnt : a;
        core_fault = bist_mode ? fault_lat : fault_sel;
        eff_addr   = core_addr ^ {{(N-1){1'b0}}, core_fault[1]};
        raw        = core_en ? (ONE_HOT0 << eff_addr) : '0;
        if (core_fault[0]) begin
            raw[W-1:H] = '0;
        end
    end

    // Result checking runs one cycle behind the sweep: the registered d
    // holds the response to the code applied last cycle, which is cnt-1.
    // In DRAIN the counter has wrapped to 0, so cnt-1 is the last code.
    always_comb begin
        check_en = ((state == RUN) && (cnt != '0)) || (state == DRAIN);
        chk_code = cnt - CNT_ONE;
        ideal    = ONE_HOT0 << chk_code;
        mismatch = check_en && (d != ideal);

        err_nxt  = err_cnt;
        ff_nxt   = first_fail;
        fv_nxt   = fail_vld;
        if (start_acc) begin
            err_nxt = '0;
            ff_nxt  = '0;
            fv_nxt  = 1'b0;
        end else if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
                err_nxt = err_cnt + ERR_ONE;
            end
            if (!fail_vld) begin
                ff_nxt = chk_code;
                fv_nxt = 1'b1;
            end
        end
    end

    // Datapath registers. done and pass are computed from the next state
    // and next error count so they rise together with the final check.
    always_ff @(posedge clk) begin
        if (rst) begin
            d          <= '0;
            cnt        <= '0;
            fault_lat  <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_vld   <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            d          <= raw;
            err_cnt    <= err_nxt;
            first_fail <= ff_nxt;
            fail_vld   <= fv_nxt;
            done       <= (state_nxt == DONE);
            pass       <= (state_nxt == DONE) && (err_nxt == '0);
            if (start_acc) begin
                cnt       <= '0;
                fault_lat <= fault_sel;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule
